// File: rtl/scroll_shift_register.sv
// Shift/rotate register with a prescaled step rate, a bounce mode that sweeps a
// WIN-bit display window back and forth, and position/direction tracking.
module scroll_shift_register #(
   parameter int WIDTH = 16,
   parameter int WIN   = 7,
   parameter int DIV   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [2:0]               mode,
   input  logic                     ser_in,
   input  logic [WIDTH-1:0]         load_data,
   output logic [WIDTH-1:0]         data_q,
   output logic [WIN-1:0]           win_out,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic                     dir,
   output logic                     step,
   output logic                     wrap,
   output logic                     turn
);

   localparam int POS_W = $clog2(WIDTH);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [POS_W-1:0] POS_MAX   = POS_W'(WIDTH - 1);
   localparam logic [POS_W-1:0] POS_TOP   = POS_W'(WIDTH - WIN);
   localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(DIV - 1);

   localparam logic [2:0] M_HOLD   = 3'b000;
   localparam logic [2:0] M_LOAD   = 3'b001;
   localparam logic [2:0] M_SHL    = 3'b010;
   localparam logic [2:0] M_SHR    = 3'b011;
   localparam logic [2:0] M_ROL    = 3'b100;
   localparam logic [2:0] M_ROR    = 3'b101;
   localparam logic [2:0] M_BOUNCE = 3'b110;
   localparam logic [2:0] M_CLEAR  = 3'b111;

   logic [CNT_W-1:0] presc;
   logic [CNT_W-1:0] presc_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic [POS_W-1:0] pos_nxt;
   logic             dir_nxt;
   logic             step_nxt;
   logic             wrap_nxt;
   logic             turn_nxt;

   logic [POS_W-1:0] pos_inc;
   logic [POS_W-1:0] pos_dec;
   logic [WIDTH-1:0] rol_val;
   logic [WIDTH-1:0] ror_val;
   logic             step_edge;
   logic             bounce_right;

   assign pos_inc   = (pos == POS_MAX) ? '0 : pos + 1'b1;
   assign pos_dec   = (pos == '0) ? POS_MAX : pos - 1'b1;
   assign rol_val   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
   assign ror_val   = {data_q[0], data_q[WIDTH-1:1]};
   assign step_edge = (presc == PRESC_MAX);

   // Moving right from pos 0 would wrap, and sitting past the top end must head
   // back down, so both override the stored direction.
   assign bounce_right = (pos != '0) && (dir || (pos >= POS_TOP));

   always_comb begin
      presc_nxt = presc;
      data_nxt  = data_q;
      pos_nxt   = pos;
      dir_nxt   = dir;
      step_nxt  = 1'b0;
      wrap_nxt  = 1'b0;
      turn_nxt  = 1'b0;
      if (en) begin
         case (mode)
            M_HOLD: presc_nxt = '0;
            M_LOAD: begin
               presc_nxt = '0;
               data_nxt  = load_data;
               pos_nxt   = '0;
               dir_nxt   = 1'b0;
            end
            M_CLEAR: begin
               presc_nxt = '0;
               data_nxt  = '0;
               pos_nxt   = '0;
               dir_nxt   = 1'b0;
            end
            default: begin
               presc_nxt = step_edge ? '0 : presc + 1'b1;
               if (step_edge) begin
                  case (mode)
                     M_SHL: begin
                        data_nxt = {data_q[WIDTH-2:0], ser_in};
                        step_nxt = 1'b1;
                     end
                     M_SHR: begin
                        data_nxt = {ser_in, data_q[WIDTH-1:1]};
                        step_nxt = 1'b1;
                     end
                     M_ROL: begin
                        data_nxt = rol_val;
                        pos_nxt  = pos_inc;
                        wrap_nxt = (pos == POS_MAX);
                        step_nxt = 1'b1;
                     end
                     M_ROR: begin
                        data_nxt = ror_val;
                        pos_nxt  = pos_dec;
                        wrap_nxt = (pos == '0);
                        step_nxt = 1'b1;
                     end
                     M_BOUNCE: begin
                        if (WIN < WIDTH) begin
                           step_nxt = 1'b1;
                           if (bounce_right) begin
                              data_nxt = ror_val;
                              pos_nxt  = pos_dec;
                              dir_nxt  = 1'b1;
                              if (pos_dec == '0) begin
                                 dir_nxt  = 1'b0;
                                 turn_nxt = 1'b1;
                              end
                           end else begin
                              data_nxt = rol_val;
                              pos_nxt  = pos_inc;
                              dir_nxt  = 1'b0;
                              if (pos_inc == POS_TOP) begin
                                 dir_nxt  = 1'b1;
                                 turn_nxt = 1'b1;
                              end
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc  <= '0;
         data_q <= '0;
         pos    <= '0;
         dir    <= 1'b0;
         step   <= 1'b0;
         wrap   <= 1'b0;
         turn   <= 1'b0;
      end else begin
         presc  <= presc_nxt;
         data_q <= data_nxt;
         pos    <= pos_nxt;
         dir    <= dir_nxt;
         step   <= step_nxt;
         wrap   <= wrap_nxt;
         turn   <= turn_nxt;
      end
   end

   assign win_out = data_q[WIDTH-1 -: WIN];

endmodule
